register_file_scrub: RTL



---
 rtl/register_file_scrub.sv | 126 ++++++++++++
 1 files changed

// File: rtl/register_file_scrub.sv
// register_file_scrub
//   Integer register file with two combinational read ports, one synchronous
//   write port, optional hardwired-zero entry 0, optional write-to-read
//   bypass, and a sequential scrub engine that clears every entry after
//   Reset or on a Clear request.
//
// Ports
//   clk    in   clock, all state updates on rising edge
//   Reset  in   synchronous active-high reset; starts a full scrub
//   A1     in   read port 1 address
//   A2     in   read port 2 address
//   A3     in   write address
//   WD3    in   write data
//   WE     in   write enable
//   Clear  in   single-cycle scrub request (honoured only while Ready=1)
//   RD1    out  read data port 1
//   RD2    out  read data port 2
//   Ready  out  1 = file usable, 0 = scrub in progress
module register_file_scrub #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE,
    input  logic              Clear,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              Ready
);

    typedef enum logic {
        SCRUB,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_discard;
    logic wr_en;
    logic scrub_en;

    // A write is lost when it targets the hardwired zero entry or collides
    // with a Clear request in the same cycle.
    assign wr_discard = (ZERO_REG != 0) && (A3 == '0);
    assign wr_en      = (state_q == READY) && WE && !Clear && !wr_discard;
    assign scrub_en   = (state_q == SCRUB) && !Reset;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= SCRUB;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SCRUB: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                    idx_d   = '0;
                end
            end
            READY: begin
                if (Clear) begin
                    state_d = SCRUB;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = SCRUB;
                idx_d   = '0;
            end
        endcase
    end

    // Storage: the scrub engine owns the array while scrubbing, writeback
    // owns it otherwise.
    always_ff @(posedge clk) begin
        if (scrub_en) begin
            mem[idx_q] <= '0;
        end else if (wr_en && !Reset) begin
            mem[A3] <= WD3;
        end
    end

    assign Ready = (state_q == READY);

    always_comb begin
        RD1 = mem[A1];
        if (!Ready) begin
            RD1 = '0;
        end else if ((ZERO_REG != 0) && (A1 == '0)) begin
            RD1 = '0;
        end else if ((BYPASS != 0) && wr_en && (A3 == A1)) begin
            RD1 = WD3;
        end
    end

    always_comb begin
        RD2 = mem[A2];
        if (!Ready) begin
            RD2 = '0;
        end else if ((ZERO_REG != 0) && (A2 == '0)) begin
            RD2 = '0;
        end else if ((BYPASS != 0) && wr_en && (A3 == A2)) begin
            RD2 = WD3;
        end
    end

endmodule
